// File: rtl/seq_shift_add_mac.sv
// Sequential shift-and-add multiplier with optional accumulate for the MAC datapath.
// One multiplier bit retires per clock through a single (W+1)-bit ripple-carry adder.

module ripple_carry_adder10 #(
  parameter int N = 17
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] sum_o
);

  logic [N-1:0] carry_s;

  assign carry_s[0] = 1'b0;

  // Carry out of the top bit is dropped: callers size N so it can never be set.
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ carry_s[i];
    if (i < N - 1) begin : g_carry
      assign carry_s[i+1] = (a_i[i] & b_i[i]) | (carry_s[i] & (a_i[i] ^ b_i[i]));
    end
  end

endmodule

module seq_shift_add_mac #(
  parameter int W     = 16,
  parameter int ACC_W = 2*W + 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       a,
  input  logic [W-1:0]       b,
  input  logic               is_signed,
  input  logic               acc_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*W-1:0]     product,
  output logic [ACC_W-1:0]   acc,
  output logic               acc_ovf
);

  localparam int CNT_W = $clog2(W);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [W-1:0]     mcand_q,   mcand_d;
  logic [W-1:0]     psum_q,    psum_d;
  logic [W-1:0]     mplier_q,  mplier_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             signed_q,  signed_d;
  logic             accen_q,   accen_d;
  logic             neg_q,     neg_d;
  logic [2*W-1:0]   product_q, product_d;
  logic [ACC_W-1:0] acc_q,     acc_d;
  logic             ovf_q,     ovf_d;

  logic [W-1:0]     a_mag_s, b_mag_s, addend_s;
  logic [W:0]       sum_s;
  logic [2*W-1:0]   mag_s, prod_s;
  logic [ACC_W-1:0] ext_s;
  logic [ACC_W:0]   acc_sum_s;
  logic             ovf_s;

  // |-2^(W-1)| wraps back to 2^(W-1), which is still correct as an unsigned magnitude.
  assign a_mag_s = (is_signed && a[W-1]) ? (~a + {{(W-1){1'b0}}, 1'b1}) : a;
  assign b_mag_s = (is_signed && b[W-1]) ? (~b + {{(W-1){1'b0}}, 1'b1}) : b;

  assign addend_s = mplier_q[0] ? mcand_q : {W{1'b0}};

  ripple_carry_adder10 #(.N(W + 1)) u_adder (
    .a_i   ({1'b0, psum_q}),
    .b_i   ({1'b0, addend_s}),
    .sum_o (sum_s)
  );

  // Final magnitude is the shifted {sum, multiplier} pair of the last step.
  assign mag_s     = {sum_s, mplier_q[W-1:1]};
  assign prod_s    = neg_q ? (~mag_s + {{(2*W-1){1'b0}}, 1'b1}) : mag_s;
  assign ext_s     = signed_q ? ACC_W'($signed(prod_s)) : ACC_W'(prod_s);
  assign acc_sum_s = {1'b0, acc_q} + {1'b0, ext_s};
  assign ovf_s     = signed_q ? ((acc_q[ACC_W-1] == ext_s[ACC_W-1]) &&
                                 (acc_sum_s[ACC_W-1] != acc_q[ACC_W-1]))
                              : acc_sum_s[ACC_W];

  // Next-state and datapath update for the IDLE/CALC/DONE sequence.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    psum_d    = psum_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    signed_d  = signed_q;
    accen_d   = accen_q;
    neg_d     = neg_q;
    product_d = product_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d  = a_mag_s;
          mplier_d = b_mag_s;
          psum_d   = {W{1'b0}};
          cnt_d    = {CNT_W{1'b0}};
          signed_d = is_signed;
          accen_d  = acc_en;
          neg_d    = is_signed & (a[W-1] ^ b[W-1]);
          state_d  = S_CALC;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_CALC: begin
        psum_d   = sum_s[W:1];
        mplier_d = {sum_s[0], mplier_q[W-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W - 1)) begin
          product_d = prod_s;
          acc_d     = accen_q ? acc_sum_s[ACC_W-1:0] : ext_s;
          ovf_d     = accen_q ? (ovf_q | ovf_s) : 1'b0;
          state_d   = S_DONE;
        end else begin
          state_d   = S_CALC;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mcand_q   <= {W{1'b0}};
      psum_q    <= {W{1'b0}};
      mplier_q  <= {W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      signed_q  <= 1'b0;
      accen_q   <= 1'b0;
      neg_q     <= 1'b0;
      product_q <= {(2*W){1'b0}};
      acc_q     <= {ACC_W{1'b0}};
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      psum_q    <= psum_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      signed_q  <= signed_d;
      accen_q   <= accen_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign product   = product_q;
  assign acc       = acc_q;
  assign acc_ovf   = ovf_q;

endmodule

// File: doc/seq_shift_add_mac.md
# seq_shift_add_mac

Multi-cycle, parametrised shift-and-add multiplier with an optional accumulate mode, for the MAC datapath. It retires one multiplier bit per clock, so one W-bit adder replaces the fully unrolled combinational array of the single-cycle multiplier. It supports unsigned and two's-complement operands, per-operation accumulate/load, and valid/ready handshakes on both sides.

## Interface
- `W`, 16: operand width in bits (W ≥ 2).
- `ACC_W`, 2*W+8: accumulator width in bits (ACC_W ≥ 2*W).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: operation request.
- `in_ready` out 1: block can accept an operation; high only in IDLE.
- `a` in W: multiplicand.
- `b` in W: multiplier.
- `is_signed` in 1: 1 = a and b are two's complement; 0 = unsigned.
- `acc_en` in 1: 1 = acc ← acc + product; 0 = acc ← product (load).
- `out_valid` out 1: product, acc and acc_ovf are valid.
- `out_ready` in 1: consumer accepts the result.
- `product` out 2W: result of the last operation.
- `acc` out ACC_W: accumulator.
- `acc_ovf` out 1: sticky accumulator overflow flag.

## Operation
- States: IDLE, CALC, DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid && in_ready, latch is_signed and acc_en.
  - Latch |a| into the multiplicand register and |b| into the multiplier shift register. Magnitude is taken only when is_signed = 1 and the MSB is set.
  - Latch neg = is_signed & (a[W-1] ^ b[W-1]).
  - Clear the partial sum and bit counter. Go to CALC.
- **CALC**, W cycles
  - Each cycle: if the multiplier LSB is 1, add the multiplicand to the upper W+1 bits of the partial sum.
  - Then shift {carry, partial sum} right by 1 and shift the multiplier right by 1.
  - Add with a `ripple_carry_adder10` instance, n = W+1.
  - On the last cycle, the counter reaches W-1:
    - product ← neg ? two's complement of the magnitude : magnitude.
    - ext = sign-extension of product to ACC_W when is_signed = 1, else zero-extension.
    - acc ← acc_en ? acc + ext : ext, modulo 2^ACC_W.
    - Go to DONE.
- **DONE**
  - out_valid = 1. product, acc and acc_ovf are held stable.
  - On out_ready, go to IDLE.
- **Magnitude rule:** |−2^(W−1)| = 2^(W−1), which fits W unsigned bits. The product magnitude is ≤ 2^(2W−2), so no internal overflow is possible.
- **acc_ovf**
  - On a load (acc_en = 0): set to 0.
  - On accumulate, unsigned: set on carry-out of the ACC_W-bit add.
  - On accumulate, signed: set when operand signs match and the result sign differs.
  - Once set, stays set until the next load or reset.
- Inputs a, b, is_signed and acc_en are ignored outside the IDLE handshake cycle. Changing them during CALC has no effect.
- in_valid asserted while in_ready = 0 is ignored; the requester holds it until accepted.

## Timing
- Reset: rst_n = 0 at a clock edge forces IDLE, whatever the current state, including mid-CALC or DONE.
  - The in-flight operation is discarded.
  - in_ready = 1; out_valid = 0; product = 0; acc = 0; acc_ovf = 0; all internal registers cleared.
- Handshake accepted at edge T: CALC occupies cycles T+1 … T+W. product, acc and acc_ovf update at edge T+W, and out_valid is high from cycle T+W+1.
- Latency from acceptance to result: W+1 cycles.
- Result accepted at edge R (out_valid && out_ready): out_valid = 0 and in_ready = 1 from cycle R+1. There is no same-cycle result/accept overlap.
- Minimum initiation interval: W+2 cycles.
- out_valid is never deasserted without out_ready. Backpressure of any length holds all outputs constant.
- acc persists across operations; it is cleared only by reset or by a load.

## Test plan
- **Unsigned max** (W=16): a=0xFFFF, b=0xFFFF, is_signed=0, acc_en=0 → out_valid at T+17; product=0xFFFE0001; acc=0x00FFFE0001; acc_ovf=0.
- **Signed mixed and corner**
  - a=0xFFFD (−3), b=0x0005, is_signed=1 → product=0xFFFFFFF1 (−15).
  - a=0x8000, b=0x8000 → product=0x40000000.
  - a=0x8000, b=0x0001 → product=0xFFFF8000.
- **Accumulate chain**
  - 100×200 with acc_en=0 → acc=20000.
  - Then 7×0xFFFE (−2), signed, acc_en=1 → product=0xFFFFFFF2; acc=19986; acc_ovf=0.
- **Overflow** (W=4, ACC_W=8), unsigned
  - 15×15 with acc_en=0 → acc=225.
  - Then 15×15 with acc_en=1 → acc=194 (450 mod 256); acc_ovf=1.
  - Then 1×1 with acc_en=1 → acc=195; acc_ovf still 1.
  - Then a load → acc_ovf=0.
- **Backpressure**: hold out_ready=0 for 5 cycles after out_valid, while toggling in_valid, a and b.
  - Outputs stay stable, in_ready stays 0, and no new operation starts.
  - Raise out_ready → in_ready=1 on the next cycle; the next operation completes with the correct result.
- **Reset mid-operation**: pull rst_n low at cycle T+5 of a 0xFFFF×0xFFFF operation.
  - Next cycle: all outputs 0 and in_ready=1.
  - A following 3×4 operation → product=12, with no residue from the aborted operation.
